dir_request_arbiter: RTL and testbench

Front-end scheduler for the MESI directory. It buffers coherence requests from `NUM_CPU` cache controllers and grants them round-robin. Each granted transaction is presented to the directory with exactly the timing the directory's IDLE/MEMORY/S_D sequencing requires. The block watches the directory's registered outputs to learn which path each request took, and it serialises the owner's follow-up response after a forwarded GetS.

---
 rtl/dir_request_arbiter_pkg.sv | 27 ++
 rtl/dir_request_arbiter_rr_picker.sv | 30 +++
 rtl/dir_request_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dir_request_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dir_request_arbiter_pkg.sv
// Shared types and transaction codes for the MESI directory request front end.
package dir_request_arbiter_pkg;

  localparam int WIDTH      = 16;
  localparam int BLOCK_SIZE = 32;
  localparam int CPU_WIDTH  = 1;

  localparam logic [3:0] FWD_GET_S          = 4'h1;
  localparam logic [3:0] FWD_GET_M          = 4'h2;
  localparam logic [3:0] FWD_PUT_S          = 4'h3;
  localparam logic [3:0] FWD_PUT_M          = 4'h4;
  localparam logic [3:0] FORWARD_DATA_PUT_M = 4'h5;

  typedef enum logic [2:0] {
    ST_ARB,
    ST_SEND,
    ST_CHECK,
    ST_WAIT_FWD,
    ST_SEND_FWD
  } state_t;

  // Owner responses that may complete a forwarded GetS.
  function automatic logic fwd_resp_ok(input logic [3:0] t);
    return (t == FWD_PUT_S) || (t == FORWARD_DATA_PUT_M);
  endfunction

endpackage

// File: rtl/dir_request_arbiter_rr_picker.sv
// Combinational round-robin selector: first valid requester at or after ptr.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  function automatic logic [IW-1:0] wrap(input int k);
    return IW'(k % N);
  endfunction

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && valid[wrap(int'(ptr) + i)]) begin
        any                         = 1'b1;
        idx                         = wrap(int'(ptr) + i);
        grant[wrap(int'(ptr) + i)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dir_request_arbiter.sv
// Buffers per-CPU coherence requests, grants them round-robin to the directory
// and serialises the owner's response after a forwarded GetS.
//
// state       | meaning
// ST_ARB      | pick next valid buffer, load payload
// ST_SEND     | dir_en_o high for one cycle
// ST_CHECK    | payload held while directory re-samples; decode path taken
// ST_WAIT_FWD | only the owner's response may be issued; watchdog runs
// ST_SEND_FWD | owner response presented, owner buffer freed
module dir_request_arbiter
  import dir_request_arbiter_pkg::*;
#(
  parameter int NUM_CPU     = 2,
  parameter int FWD_TIMEOUT = 64
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [NUM_CPU-1:0]            req_valid_i,
  output logic [NUM_CPU-1:0]            req_ready_o,
  input  logic [NUM_CPU*4-1:0]          req_type_i,
  input  logic [NUM_CPU*WIDTH-1:0]      req_addr_i,
  input  logic [NUM_CPU*BLOCK_SIZE-1:0] req_data_i,
  output logic                          dir_en_o,
  output logic [3:0]                    dir_type_o,
  output logic [WIDTH-1:0]              dir_addr_o,
  output logic [BLOCK_SIZE-1:0]         dir_data_o,
  output logic [CPU_WIDTH-1:0]          dir_requester_o,
  input  logic                          dir_mem_read_i,
  input  logic                          dir_fwd_en_i,
  input  logic [3:0]                    dir_fwd_type_i,
  input  logic [CPU_WIDTH-1:0]          dir_fwd_dest_i,
  output logic [NUM_CPU-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          timeout_o
);

  localparam int WDW = $clog2(FWD_TIMEOUT + 1);

  state_t                state;
  logic [NUM_CPU-1:0]    buf_valid;
  logic [3:0]            buf_type [NUM_CPU];
  logic [WIDTH-1:0]      buf_addr [NUM_CPU];
  logic [BLOCK_SIZE-1:0] buf_data [NUM_CPU];
  logic [CPU_WIDTH-1:0]  rr, cur, owner;
  logic [WDW-1:0]        wd_cnt;

  logic [NUM_CPU-1:0]    pick_grant;
  logic [CPU_WIDTH-1:0]  pick_idx;
  logic                  pick_any;

  rr_picker #(.N(NUM_CPU), .IW(CPU_WIDTH)) u_pick (
    .valid (buf_valid),
    .ptr   (rr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign req_ready_o = ~buf_valid;
  assign busy_o      = (state != ST_ARB);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state           <= ST_ARB;
      buf_valid       <= '0;
      rr              <= '0;
      cur             <= '0;
      owner           <= '0;
      wd_cnt          <= '0;
      dir_en_o        <= 1'b0;
      dir_type_o      <= '0;
      dir_addr_o      <= '0;
      dir_data_o      <= '0;
      dir_requester_o <= '0;
      grant_o         <= '0;
      timeout_o       <= 1'b0;
      for (int c = 0; c < NUM_CPU; c++) begin
        buf_type[c] <= '0;
        buf_addr[c] <= '0;
        buf_data[c] <= '0;
      end
    end else begin
      // Accept never collides with a free: ready is low while a buffer is valid.
      for (int c = 0; c < NUM_CPU; c++) begin
        if (req_valid_i[c] && !buf_valid[c]) begin
          buf_valid[c] <= 1'b1;
          buf_type[c]  <= req_type_i[c*4 +: 4];
          buf_addr[c]  <= req_addr_i[c*WIDTH +: WIDTH];
          buf_data[c]  <= req_data_i[c*BLOCK_SIZE +: BLOCK_SIZE];
        end
      end

      dir_en_o <= 1'b0;

      case (state)
        ST_ARB: begin
          if (pick_any) begin
            grant_o         <= pick_grant;
            cur             <= pick_idx;
            dir_type_o      <= buf_type[pick_idx];
            dir_addr_o      <= buf_addr[pick_idx];
            dir_data_o      <= buf_data[pick_idx];
            dir_requester_o <= pick_idx;
            rr              <= (int'(pick_idx) == NUM_CPU - 1) ? '0 : pick_idx + 1'b1;
            dir_en_o        <= 1'b1;
            state           <= ST_SEND;
          end
        end

        ST_SEND: state <= ST_CHECK;

        ST_CHECK: begin
          buf_valid[cur]  <= 1'b0;
          grant_o         <= '0;
          dir_type_o      <= '0;
          dir_addr_o      <= '0;
          dir_data_o      <= '0;
          dir_requester_o <= '0;
          if (dir_mem_read_i) begin
            state <= ST_ARB;
          end else if (dir_fwd_en_i && dir_fwd_type_i == FWD_GET_S) begin
            owner  <= dir_fwd_dest_i;
            wd_cnt <= WDW'(FWD_TIMEOUT - 1);
            state  <= ST_WAIT_FWD;
          end else begin
            state <= ST_ARB;
          end
        end

        ST_WAIT_FWD: begin
          if (buf_valid[owner] && fwd_resp_ok(buf_type[owner])) begin
            grant_o         <= NUM_CPU'(1) << owner;
            dir_type_o      <= buf_type[owner];
            dir_addr_o      <= buf_addr[owner];
            dir_data_o      <= buf_data[owner];
            dir_requester_o <= owner;
            dir_en_o        <= 1'b1;
            state           <= ST_SEND_FWD;
          end else if (wd_cnt == '0) begin
            timeout_o <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end

        ST_SEND_FWD: begin
          buf_valid[owner] <= 1'b0;
          grant_o          <= '0;
          dir_type_o       <= '0;
          dir_addr_o       <= '0;
          dir_data_o       <= '0;
          dir_requester_o  <= '0;
          state            <= ST_ARB;
        end

        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dir_request_arbiter.sv
// Randomised bench: a schedule-based reference predicts every output cycle by cycle.
module tb_dir_request_arbiter;
  import dir_request_arbiter_pkg::*;

  localparam int NC   = 2;
  localparam int TO   = 8;
  localparam int NCYC = 3000;
  localparam int NEVR = 1 << 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     sys_rst;
  logic [NC-1:0]            req_valid, req_ready, grant;
  logic [NC*4-1:0]          req_type;
  logic [NC*WIDTH-1:0]      req_addr;
  logic [NC*BLOCK_SIZE-1:0] req_data;
  logic                     dir_en, dir_mem_read, dir_fwd_en, busy, timeout;
  logic [3:0]               dir_type, dir_fwd_type;
  logic [WIDTH-1:0]         dir_addr;
  logic [BLOCK_SIZE-1:0]    dir_data;
  logic [CPU_WIDTH-1:0]     dir_requester, dir_fwd_dest;

  dir_request_arbiter #(.NUM_CPU(NC), .FWD_TIMEOUT(TO)) dut (
    .sys_clk(clk), .sys_rst(sys_rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_type_i(req_type), .req_addr_i(req_addr), .req_data_i(req_data),
    .dir_en_o(dir_en), .dir_type_o(dir_type), .dir_addr_o(dir_addr),
    .dir_data_o(dir_data), .dir_requester_o(dir_requester),
    .dir_mem_read_i(dir_mem_read), .dir_fwd_en_i(dir_fwd_en),
    .dir_fwd_type_i(dir_fwd_type), .dir_fwd_dest_i(dir_fwd_dest),
    .grant_o(grant), .busy_o(busy), .timeout_o(timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs per cycle, and directory stimulus scheduled for CHECK cycles.
  bit                  e_en   [NCYC+8];
  bit [3:0]            e_type [NCYC+8];
  bit [WIDTH-1:0]      e_addr [NCYC+8];
  bit [BLOCK_SIZE-1:0] e_data [NCYC+8];
  bit                  e_req  [NCYC+8];
  bit [NC-1:0]         e_grant[NCYC+8];
  bit                  e_busy [NCYC+8];
  bit                  d_sched[NCYC+8];
  bit                  d_mem  [NCYC+8];
  bit                  d_fen  [NCYC+8];
  bit [3:0]            d_ftype[NCYC+8];
  bit                  d_dest [NCYC+8];

  bit                  mv [NC];
  bit [3:0]            mt [NC];
  bit [WIDTH-1:0]      ma [NC];
  bit [BLOCK_SIZE-1:0] md [NC];
  int                  free_cyc [NC];
  bit                  ready_now [NC];
  int                  rr, free_at, owner, wait_from;
  bit                  m_to;

  logic [3:0] tlist [6] = '{FWD_GET_S, FWD_GET_M, FWD_PUT_S, FWD_PUT_M, FORWARD_DATA_PUT_M, 4'hF};

  task automatic sched_issue(input int t, input int c, input int span);
    for (int k = 1; k <= span; k++) begin
      e_type[t+k]  = mt[c];
      e_addr[t+k]  = ma[c];
      e_data[t+k]  = md[c];
      e_req[t+k]   = c[0];
      e_grant[t+k] = NC'(1) << c;
      e_busy[t+k]  = 1'b1;
    end
    e_en[t+1] = 1'b1;
  endtask

  initial begin
    logic [56:0] got_v, exp_v;
    bit do_rst;
    int g, c, r, sub;

    sys_rst = 1'b1;
    req_valid = '0; req_type = '0; req_addr = '0; req_data = '0;
    dir_mem_read = 1'b0; dir_fwd_en = 1'b0; dir_fwd_type = '0; dir_fwd_dest = '0;
    for (int i = 0; i < NC; i++) begin
      mv[i] = 1'b0; free_cyc[i] = -1;
    end
    rr = 0; free_at = 1; owner = -1; wait_from = 0; m_to = 1'b0;
    @(posedge clk);

    for (int t = 1; t <= NCYC; t++) begin
      @(negedge clk);
      got_v = {dir_en, dir_type, dir_addr, dir_data, dir_requester, grant, busy};
      exp_v = {e_en[t], e_type[t], e_addr[t], e_data[t], e_req[t], e_grant[t], e_busy[t]};
      check_val("dir_outputs", 64'(got_v), 64'(exp_v));
      check_val("req_ready", 64'(req_ready), 64'({!mv[1], !mv[0]}));
      check_val("timeout", 64'(timeout), 64'(m_to));

      do_rst = (owner >= 0 && t >= wait_from && t - wait_from >= 12) ||
               ($urandom_range(0, 299) == 0);
      sys_rst = do_rst;
      for (int i = 0; i < NC; i++) begin
        req_valid[i] = !do_rst && ($urandom_range(0, 99) < 40);
        req_type[i*4 +: 4] = tlist[$urandom_range(0, 5)];
        req_addr[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        req_data[i*BLOCK_SIZE +: BLOCK_SIZE] = BLOCK_SIZE'($urandom);
      end
      if (d_sched[t]) begin
        dir_mem_read = d_mem[t]; dir_fwd_en = d_fen[t];
        dir_fwd_type = d_ftype[t]; dir_fwd_dest = d_dest[t];
      end else begin
        dir_mem_read = 1'($urandom); dir_fwd_en = 1'($urandom);
        dir_fwd_type = 4'($urandom); dir_fwd_dest = 1'($urandom);
      end

      if (do_rst) begin
        for (int i = 0; i < NC; i++) begin
          mv[i] = 1'b0; free_cyc[i] = -1;
        end
        for (int k = 1; k <= 3; k++) begin
          e_en[t+k] = 0; e_type[t+k] = 0; e_addr[t+k] = 0; e_data[t+k] = 0;
          e_req[t+k] = 0; e_grant[t+k] = 0; e_busy[t+k] = 0; d_sched[t+k] = 0;
        end
        rr = 0; free_at = t + 1; owner = -1; m_to = 1'b0;
        continue;
      end

      for (int i = 0; i < NC; i++) ready_now[i] = !mv[i];

      if (owner < 0 && t >= free_at) begin
        g = -1;
        for (int i = 0; i < NC; i++) begin
          c = (rr + i) % NC;
          if (g < 0 && mv[c]) g = c;
        end
        if (g >= 0) begin
          sched_issue(t, g, 2);
          rr = (g + 1) % NC;
          free_cyc[g] = t + 2;
          free_at = t + 3;
          r = $urandom_range(0, 99);
          d_sched[t+2] = 1'b1;
          d_dest[t+2]  = 1'($urandom);
          if (r < 35) begin
            d_mem[t+2] = 1'b1; d_fen[t+2] = 1'($urandom); d_ftype[t+2] = FWD_GET_S;
          end else if (r < 70) begin
            d_mem[t+2] = 1'b0; d_fen[t+2] = 1'b1; d_ftype[t+2] = FWD_GET_S;
            owner = int'(d_dest[t+2]); wait_from = t + 3; free_at = NEVR;
            e_busy[t+3] = 1'b1;
          end else begin
            sub = $urandom_range(0, 2);
            d_mem[t+2]   = 1'b0;
            d_fen[t+2]   = (sub != 1);
            d_ftype[t+2] = (sub == 0) ? FWD_GET_M : (sub == 1) ? FWD_GET_S : 4'hF;
          end
        end
      end else if (owner >= 0 && t >= wait_from) begin
        if (mv[owner] && (mt[owner] == FWD_PUT_S || mt[owner] == FORWARD_DATA_PUT_M)) begin
          sched_issue(t, owner, 1);
          free_cyc[owner] = t + 1;
          free_at = t + 2;
          owner = -1;
        end else begin
          e_busy[t+1] = 1'b1;
          if (t - wait_from + 1 >= TO) m_to = 1'b1;
        end
      end

      for (int i = 0; i < NC; i++) begin
        if (free_cyc[i] == t) begin
          mv[i] = 1'b0; free_cyc[i] = -1;
        end
        if (req_valid[i] && ready_now[i]) begin
          mv[i] = 1'b1;
          mt[i] = req_type[i*4 +: 4];
          ma[i] = req_addr[i*WIDTH +: WIDTH];
          md[i] = req_data[i*BLOCK_SIZE +: BLOCK_SIZE];
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
